// File: rtl/mul_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// The optional MUL_EARLY_OUT_EN build lets multiplies end early; it does not change anything here.
package mul_div_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mul_div_sign_fix.sv
// Two-lane conditional two's-complement negate. With link set, a:b is negated as one
// double-width value (product); otherwise each lane is negated on its own (operands, quotient/remainder).
module mul_div_sign_fix
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             neg_a,
    input  logic             neg_b,
    input  logic             link,
    output logic [WIDTH-1:0] res_a,
    output logic [WIDTH-1:0] res_b
);

    logic [2*WIDTH-1:0] wide_neg;

    // NOTE: every path assigns both outputs, so this block stays purely combinational (no latch).
    always_comb begin
        wide_neg = -{a, b};
        if (link) begin
            {res_a, res_b} = neg_a ? wide_neg : {a, b};
        end else begin
            res_a = neg_a ? -a : a;
            res_b = neg_b ? -b : b;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit writing HI/LO after one radix-2 step per cycle.
// Define MUL_EARLY_OUT_EN to end multiplies as soon as the remaining multiplier bits are zero.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 is_div_q, quo_sign, rem_sign, dz_pend;
    logic [2*WIDTH-1:0]   acc, mcand_sh;
    logic [WIDTH-1:0]     b_reg, rem, quo;
    logic [WIDTH-1:0]     hi, lo;
    logic                 done, div_zero;

    // Operand conditioning: magnitudes for signed ops, raw values otherwise.
    logic             is_div_in, s1, s2, dz_in;
    logic [WIDTH-1:0] mag1, mag2;

    assign is_div_in = op_i[1];
    assign s1        = ~op_i[0] & src1_i[WIDTH-1];
    assign s2        = ~op_i[0] & src2_i[WIDTH-1];
    assign dz_in     = is_div_in && (src2_i == '0);

    mul_div_sign_fix #(.WIDTH(WIDTH)) u_operand_fix (
        .a     (src1_i),
        .b     (src2_i),
        .neg_a (s1),
        .neg_b (s2),
        .link  (1'b0),
        .res_a (mag1),
        .res_b (mag2)
    );

    // Result correction: 2*WIDTH negate for products, per-lane for quotient/remainder.
    logic [WIDTH-1:0] fix_hi, fix_lo;

    mul_div_sign_fix #(.WIDTH(WIDTH)) u_result_fix (
        .a     (is_div_q ? rem : acc[2*WIDTH-1:WIDTH]),
        .b     (is_div_q ? quo : acc[WIDTH-1:0]),
        .neg_a (is_div_q ? rem_sign : quo_sign),
        .neg_b (quo_sign),
        .link  (~is_div_q),
        .res_a (fix_hi),
        .res_b (fix_lo)
    );

    // Restoring divide step on a WIDTH+1 bit shifted partial remainder. If the top bit is
    // set the value already exceeds any divisor; otherwise diff[WIDTH] is the borrow.
    logic [WIDTH:0] rem_sh, diff;
    logic           ge;

    assign rem_sh = {rem, quo[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, b_reg};
    assign ge     = rem_sh[WIDTH] | ~diff[WIDTH];

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_i) begin
                    if (dz_in) begin
                        state_nxt = FIX;
`ifdef MUL_EARLY_OUT_EN
                    end else if (!is_div_in && mag2 == '0) begin
                        state_nxt = FIX;
`endif
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    state_nxt = FIX;
`ifdef MUL_EARLY_OUT_EN
                end else if (!is_div_q && b_reg[WIDTH-1:1] == '0) begin
                    state_nxt = FIX;
`endif
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy_o = (state == RUN) || (state == FIX);
    end

    // NOTE: every datapath register is reset, so an aborted operation leaves no stale state behind.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            quo_sign <= 1'b0;
            rem_sign <= 1'b0;
            dz_pend  <= 1'b0;
            acc      <= '0;
            mcand_sh <= '0;
            b_reg    <= '0;
            rem      <= '0;
            quo      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        is_div_q <= is_div_in;
                        quo_sign <= s1 ^ s2;
                        rem_sign <= s1;
                        dz_pend  <= dz_in;
                        div_zero <= 1'b0;
                        cnt      <= '0;
                        acc      <= '0;
                        mcand_sh <= {{WIDTH{1'b0}}, mag1};
                        b_reg    <= mag2;
                        rem      <= '0;
                        // A divide by zero skips RUN and reports the raw dividend in HI.
                        quo      <= dz_in ? src1_i : mag1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div_q) begin
                        rem <= ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                        quo <= {quo[WIDTH-2:0], ge};
                    end else begin
                        if (b_reg[0]) acc <= acc + mcand_sh;
                        mcand_sh <= mcand_sh << 1;
                        b_reg    <= b_reg >> 1;
                    end
                end
                FIX: begin
                    if (dz_pend) begin
                        hi       <= quo;
                        lo       <= '1;
                        div_zero <= 1'b1;
                    end else begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign done_o     = done;
    assign div_zero_o = div_zero;
    assign hi_o       = hi;
    assign lo_o       = lo;

endmodule
